pipeline_control_sequencer: RTL

Stage sequencer and control-signal generator for the multi-cycle AVR core. It owns the IF→ID→EX→MEM→WB stage register and latches the decoded opcode group in ID. It drives every `CONTROL_*` signal gated by the current stage, stretches MEM for memory wait states and for IO handshakes, and reports instruction completion. It sits between the decoder and the register file, data memory and IO bus.

---
 rtl/pipeline_control_sequencer_if.sv | 60 ++++++
 rtl/pipeline_control_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_sequencer_if.sv
// Shared constants and the decoder/datapath-facing bundle of the pipeline
// control sequencer. The slave modport is the sequencer; the master modport
// is whoever drives the decoded opcode and consumes the control vector.
package pipeline_control_sequencer_pkg;
  localparam int OPCODE_COUNT = 8;
  localparam int GROUP_COUNT  = 10;
  localparam int STAGE_COUNT  = 3;
  localparam int SIGNAL_COUNT = 8;

  localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 3'd0;
  localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 3'd1;
  localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 3'd2;
  localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 3'd3;
  localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 3'd4;

  localparam int GROUP_ALU            = 0;
  localparam int GROUP_ALU_TWO_OP     = 1;
  localparam int GROUP_ALU_IMD        = 2;
  localparam int GROUP_REGISTER       = 3;
  localparam int GROUP_LOAD           = 4;
  localparam int GROUP_STORE          = 5;
  localparam int GROUP_LOAD_INDIRECT  = 6;
  localparam int GROUP_STORE_INDIRECT = 7;
  localparam int GROUP_IO_READ        = 8;
  localparam int GROUP_IO_WRITE       = 9;

  localparam int CONTROL_RR_READ   = 0;
  localparam int CONTROL_RD_READ   = 1;
  localparam int CONTROL_RD_WRITE  = 2;
  localparam int CONTROL_RR_WRITE  = 3;
  localparam int CONTROL_MEM_READ  = 4;
  localparam int CONTROL_MEM_WRITE = 5;
  localparam int CONTROL_IO_READ   = 6;
  localparam int CONTROL_IO_WRITE  = 7;
endpackage

interface pipeline_control_sequencer_if;
  import pipeline_control_sequencer_pkg::*;

  logic                    stall;
  logic [OPCODE_COUNT-1:0] opcode_type;
  logic [GROUP_COUNT-1:0]  opcode_group;
  logic                    io_ready;
  logic [STAGE_COUNT-1:0]  pipeline_stage;
  logic [SIGNAL_COUNT-1:0] signals;
  logic                    instr_done;
  logic                    io_error;
  // opcode registered at the end of ID, for the downstream datapath
  logic [OPCODE_COUNT-1:0] opcode_latched;

  modport master (
    output stall, opcode_type, opcode_group, io_ready,
    input  pipeline_stage, signals, instr_done, io_error, opcode_latched
  );

  modport slave (
    input  stall, opcode_type, opcode_group, io_ready,
    output pipeline_stage, signals, instr_done, io_error, opcode_latched
  );
endinterface

// File: rtl/pipeline_control_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage sequencer and control-vector generator.
// Optional feature macro: IO_HANDSHAKE_EN -- when defined, IO accesses in MEM
// wait for io_ready with a timeout that pulses io_error; when undefined, IO
// accesses take one MEM cycle and io_error is tied low.
module pipeline_control_sequencer
  import pipeline_control_sequencer_pkg::*;
#(
  parameter int MEM_WAIT   = 0,
  parameter int IO_TIMEOUT = 8
) (
  input logic                       clk,
  input logic                       reset,
  pipeline_control_sequencer_if.slave bus
);
  localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

  typedef enum logic [STAGE_COUNT-1:0] {
    S_IF  = STAGE_IF,
    S_ID  = STAGE_ID,
    S_EX  = STAGE_EX,
    S_MEM = STAGE_MEM,
    S_WB  = STAGE_WB
  } stage_t;

  stage_t                  stage;
  logic [GROUP_COUNT-1:0]  grp_q;
  logic [OPCODE_COUNT-1:0] opc_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    instr_done_q;
  logic                    io_error_q;
  logic                    io_fail_w;
  logic                    io_sat;
  logic                    mem_ok;
  logic                    mem_exit;
  logic [SIGNAL_COUNT-1:0] sig;
  logic [GROUP_COUNT-1:0]  g_live;
  logic                    unused_grp_q;

  assign g_live   = bus.opcode_group;
  assign mem_ok   = !(grp_q[GROUP_LOAD] | grp_q[GROUP_STORE]) || (wait_cnt == '0);
  assign mem_exit = mem_ok && io_sat;
  // these groups only affect the ID-stage reads, which use the live vector
  assign unused_grp_q = ^{grp_q[GROUP_ALU_TWO_OP], grp_q[GROUP_ALU_IMD],
                          grp_q[GROUP_LOAD_INDIRECT], grp_q[GROUP_STORE_INDIRECT]};

`ifdef IO_HANDSHAKE_EN
  logic [7:0] io_cnt;
  logic       io_ok;
  logic       io_fail;
  logic       io_grp;
  logic       io_abort_next;

  assign io_grp    = grp_q[GROUP_IO_READ] | grp_q[GROUP_IO_WRITE];
  assign io_fail_w = io_fail;
  // io_error_q marks the abort cycle itself, so the access is satisfied there
  assign io_sat    = !io_grp || io_ok || io_fail || io_error_q || bus.io_ready;
  assign io_abort_next = io_grp && !io_ok && !io_fail && !io_error_q && !bus.io_ready &&
                         ((int'(io_cnt) + 2) == IO_TIMEOUT);

  // IO handshake bookkeeping: MEM cycle count, acknowledge and timeout flags
  always_ff @(posedge clk) begin
    if (reset) begin
      io_cnt     <= '0;
      io_ok      <= 1'b0;
      io_fail    <= 1'b0;
      io_error_q <= 1'b0;
    end else if (!bus.stall) begin
      case (stage)
        S_EX: begin
          io_cnt     <= '0;
          io_ok      <= 1'b0;
          io_fail    <= 1'b0;
          io_error_q <= io_grp && (IO_TIMEOUT == 1);
        end
        S_MEM: begin
          io_fail <= io_fail | io_error_q;
          if (mem_exit) begin
            io_error_q <= 1'b0;
          end else begin
            if (io_cnt != 8'hFF) io_cnt <= io_cnt + 8'd1;
            io_ok      <= io_ok | (bus.io_ready && !io_error_q);
            io_error_q <= io_abort_next;
          end
        end
        S_WB: begin
          io_fail    <= 1'b0;
          io_error_q <= 1'b0;
        end
        default: io_error_q <= 1'b0;
      endcase
    end
  end
`else
  logic unused_io_ready;

  assign io_sat          = 1'b1;
  assign io_fail_w       = 1'b0;
  assign io_error_q      = 1'b0;
  assign unused_io_ready = bus.io_ready;
`endif

  // Stage FSM: advances once per unstalled cycle, MEM stretched by wait/IO
  always_ff @(posedge clk) begin
    if (reset) begin
      stage        <= S_IF;
      grp_q        <= '0;
      opc_q        <= '0;
      wait_cnt     <= '0;
      instr_done_q <= 1'b0;
    end else if (!bus.stall) begin
      instr_done_q <= 1'b0;
      case (stage)
        S_IF: stage <= S_ID;
        S_ID: begin
          stage <= S_EX;
          grp_q <= bus.opcode_group;
          opc_q <= bus.opcode_type;
        end
        S_EX: begin
          stage    <= S_MEM;
          wait_cnt <= WAIT_INIT;
        end
        S_MEM: begin
          if (mem_exit) begin
            stage        <= S_WB;
            instr_done_q <= 1'b1;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_WB:    stage <= S_IF;
        default: stage <= S_IF;
      endcase
    end
  end

  // Stage-gated control vector; ID reads decode from the live group
  always_comb begin
    sig = '0;
    case (stage)
      S_ID: begin
        sig[CONTROL_RR_READ] = g_live[GROUP_ALU_TWO_OP] | g_live[GROUP_LOAD_INDIRECT] |
                               g_live[GROUP_REGISTER] | g_live[GROUP_STORE] |
                               g_live[GROUP_IO_WRITE];
        sig[CONTROL_RD_READ] = g_live[GROUP_ALU] | g_live[GROUP_ALU_IMD] |
                               g_live[GROUP_STORE_INDIRECT] | g_live[GROUP_LOAD_INDIRECT];
      end
      S_MEM: begin
        sig[CONTROL_MEM_READ]  = grp_q[GROUP_LOAD];
        sig[CONTROL_MEM_WRITE] = grp_q[GROUP_STORE];
        sig[CONTROL_IO_READ]   = grp_q[GROUP_IO_READ];
        sig[CONTROL_IO_WRITE]  = grp_q[GROUP_IO_WRITE];
      end
      S_WB: begin
        sig[CONTROL_RD_WRITE] = (grp_q[GROUP_ALU] | grp_q[GROUP_REGISTER] |
                                 grp_q[GROUP_LOAD] | grp_q[GROUP_IO_READ]) & !io_fail_w;
      end
      default: sig = '0;
    endcase
  end

  assign bus.pipeline_stage = stage;
  assign bus.signals        = sig;
  assign bus.instr_done     = instr_done_q;
  assign bus.io_error       = io_error_q;
  assign bus.opcode_latched = opc_q;
endmodule
